pipe_hazard_ctrl: RTL

//  Hazard/forwarding scheduler for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/hazard_src_cmp.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scheduler.
// Build option: FORWARDING_EN selects operand bypassing; when it is undefined
// every dependency is resolved by stalling.
package pipe_pkg;

    localparam int RA_W = 5;
    localparam logic [RA_W-1:0] REG_ZERO = '0;

    // Operand source select presented to the EX-stage operand muxes
    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_EALU = 2'b01,
        FWD_MALU = 2'b10,
        FWD_MMEM = 2'b11
    } fwd_e;

    // Shadow copy of one in-flight instruction's destination info
    typedef struct packed {
        logic            v;
        logic            wreg;
        logic [RA_W-1:0] rn;
        logic            m2reg;
    } shadow_t;

    // True when the shadowed instruction will write register r (r0 never counts)
    function automatic logic writes_reg(input shadow_t s, input logic [RA_W-1:0] r);
        return s.v && s.wreg && (s.rn != REG_ZERO) && (s.rn == r);
    endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// Per-operand dependency check of one ID source register against the
// instructions shadowed in EX and MEM. Build option: FORWARDING_EN.
module hazard_src_cmp
    import pipe_pkg::*;
(
    input  logic            id_valid,
    input  logic            use_src,
    input  logic [RA_W-1:0] src,
    input  shadow_t         e_stage,
    input  shadow_t         m_stage,
    output logic [1:0]      fwd,
    output logic            hazard,
    output logic            load_use
);

    logic       e_hit;
    logic       m_hit;
    logic [1:0] sel;

    assign e_hit    = id_valid && use_src && writes_reg(e_stage, src);
    assign m_hit    = id_valid && use_src && writes_reg(m_stage, src);
    assign load_use = e_hit && e_stage.m2reg;

    // Youngest producer wins; a load still in EX has no data to bypass yet
    always_comb begin
        sel = FWD_RF;
        if (e_hit) begin
            sel = e_stage.m2reg ? FWD_RF : FWD_EALU;
        end else if (m_hit) begin
            sel = m_stage.m2reg ? FWD_MMEM : FWD_MALU;
        end
    end

`ifdef FORWARDING_EN
    assign fwd    = sel;
    assign hazard = load_use;
`else
    // Without bypass paths, anything that would have needed one must wait
    assign fwd    = FWD_RF;
    assign hazard = load_use || (sel != FWD_RF);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding scheduler beside the ID stage of the 5-stage pipeline.
// Shadows EX and MEM destinations, picks operand bypass sources, inserts
// load-use stalls and bubbles flushed slots. Build option: FORWARDING_EN.
// The WB stage is not shadowed: the register file writes in the first half
// cycle, so an instruction in WB can never create a hazard.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [RA_W-1:0]  id_rn,
    input  logic             id_m2reg,
    input  logic             ex_flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             exe_load,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    shadow_t          e_q, e_d, m_q;
    logic             haz_a, haz_b;
    logic             lu_a, lu_b;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    hazard_src_cmp u_cmp_a (
        .id_valid (id_valid),
        .use_src  (id_use_rs),
        .src      (id_rs),
        .e_stage  (e_q),
        .m_stage  (m_q),
        .fwd      (fwd_a),
        .hazard   (haz_a),
        .load_use (lu_a)
    );

    hazard_src_cmp u_cmp_b (
        .id_valid (id_valid),
        .use_src  (id_use_rt),
        .src      (id_rt),
        .e_stage  (e_q),
        .m_stage  (m_q),
        .fwd      (fwd_b),
        .hazard   (haz_b),
        .load_use (lu_b)
    );

    // A flush kills the ID slot, so it overrides any stall request
    assign exe_load = lu_a || lu_b;
    assign stall    = (haz_a || haz_b) && !ex_flush;
    assign bubble   = stall || ex_flush;

    // Only a live instruction that actually leaves ID enters the EX shadow
    always_comb begin
        e_d = '0;
        if (id_valid && !bubble) begin
            e_d = '{v: 1'b1, wreg: id_wreg, rn: id_rn, m2reg: id_m2reg};
        end
    end

    // Shadow pipeline advances every cycle; bubbles enter as invalid slots
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= e_q;
        end
    end

    // Next values of the saturating performance counters
    always_comb begin
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (ex_flush && id_valid) ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // Performance counter registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
